// File: rtl/ip_codma_burst_packer.sv
// Two-bank ping-pong packer: collects up to WORDS read words into one burst block
// for the CoDMA CRC engine and presents it with a valid/ready handshake.
module ip_codma_burst_packer #(
    parameter int WORDS  = 8,
    parameter int DATA_W = 32
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [DATA_W-1:0]                rd_data_i,
    input  logic                             rd_valid_i,
    input  logic                             rd_last_i,
    output logic                             rd_ready_o,
    input  logic                             flush_i,
    output logic [WORDS-1:0][DATA_W-1:0]     data_reg_o,
    output logic [$clog2(WORDS):0]           word_cnt_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i
);

    localparam int IW = $clog2(WORDS);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_t;

    bank_state_t                     r_state [2];
    logic [WORDS-1:0][DATA_W-1:0]    r_data  [2];
    logic [CW-1:0]                   r_cnt   [2];
    logic                            r_fill_sel;
    logic                            r_drain_sel;
    logic [IW-1:0]                   r_idx;
    logic                            r_run;

    logic w_accept;
    logic w_close;
    logic w_handoff;

    // r_run holds rd_ready_o low until the first clock after reset release
    assign rd_ready_o  = r_run && (r_state[r_fill_sel] != BANK_FULL);
    assign out_valid_o = (r_state[r_drain_sel] == BANK_FULL);
    assign data_reg_o  = out_valid_o ? r_data[r_drain_sel] : '0;
    assign word_cnt_o  = out_valid_o ? r_cnt[r_drain_sel] : '0;

    assign w_accept  = rd_valid_i && rd_ready_o;
    assign w_close   = w_accept && ((r_idx == IW'(WORDS - 1)) || rd_last_i);
    assign w_handoff = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned b = 0; b < 2; b++) begin
                r_state[b] <= BANK_EMPTY;
                r_data[b]  <= '0;
                r_cnt[b]   <= '0;
            end
            r_fill_sel  <= 1'b0;
            r_drain_sel <= 1'b0;
            r_idx       <= '0;
            r_run       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (flush_i) begin
                r_state[0]  <= BANK_EMPTY;
                r_state[1]  <= BANK_EMPTY;
                r_fill_sel  <= 1'b0;
                r_drain_sel <= 1'b0;
                r_idx       <= '0;
            end else begin
                if (w_accept) begin
                    r_data[r_fill_sel][r_idx] <= rd_data_i;
                    if (w_close) begin
                        // Zero the tail so a short block never shows stale words
                        for (int unsigned w = 0; w < WORDS; w++) begin
                            if (IW'(w) > r_idx) begin
                                r_data[r_fill_sel][w] <= '0;
                            end
                        end
                        r_state[r_fill_sel] <= BANK_FULL;
                        r_cnt[r_fill_sel]   <= CW'(r_idx) + CW'(1);
                        r_idx               <= '0;
                        r_fill_sel          <= ~r_fill_sel;
                    end else begin
                        r_state[r_fill_sel] <= BANK_FILLING;
                        r_idx               <= r_idx + 1'b1;
                    end
                end
                // The drain bank is FULL, so it is never the bank being written above
                if (w_handoff) begin
                    r_state[r_drain_sel] <= BANK_EMPTY;
                    r_drain_sel          <= ~r_drain_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_ip_codma_burst_packer.sv
// Scoreboard bench for ip_codma_burst_packer: a model packs accepted words into
// expected blocks, which are compared when the DUT hands a block off.
module tb_ip_codma_burst_packer;

    localparam int WORDS  = 8;
    localparam int DATA_W = 32;

    logic                          clk_i = 1'b0;
    logic                          reset_n_i;
    logic [DATA_W-1:0]             rd_data_i;
    logic                          rd_valid_i;
    logic                          rd_last_i;
    logic                          rd_ready_o;
    logic                          flush_i;
    logic [WORDS-1:0][DATA_W-1:0]  data_reg_o;
    logic [$clog2(WORDS):0]        word_cnt_o;
    logic                          out_valid_o;
    logic                          out_ready_i;

    ip_codma_burst_packer #(.WORDS(WORDS), .DATA_W(DATA_W)) u_dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .rd_data_i   (rd_data_i),
        .rd_valid_i  (rd_valid_i),
        .rd_last_i   (rd_last_i),
        .rd_ready_o  (rd_ready_o),
        .flush_i     (flush_i),
        .data_reg_o  (data_reg_o),
        .word_cnt_o  (word_cnt_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [WORDS-1:0][DATA_W-1:0] data;
        int                           cnt;
    } block_t;

    block_t                        sb_q[$];
    logic [WORDS-1:0][DATA_W-1:0]  m_part;
    int                            m_idx;
    int                            n_checks = 0;
    int                            n_errors = 0;
    int                            cyc = 0;
    int                            hs_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_part = '0;
        m_idx  = 0;
    endtask

    task automatic model_accept(input logic [DATA_W-1:0] d, input logic last);
        block_t b;
        m_part[m_idx] = d;
        m_idx++;
        if (m_idx == WORDS || last) begin
            b.data = m_part;
            b.cnt  = m_idx;
            sb_q.push_back(b);
            model_clear();
        end
    endtask

    // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
    task automatic step(output bit acc);
        block_t b;
        @(negedge clk_i);
        acc = rd_valid_i && rd_ready_o && !flush_i;
        if (out_valid_o && out_ready_i) begin
            hs_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                check("unexpected_block", 1'b1, 1'b0);
            end else begin
                b = sb_q.pop_front();
                check("blk_cnt", 64'(word_cnt_o), 64'(b.cnt));
                for (int i = 0; i < WORDS; i++)
                    check($sformatf("blk_w%0d", i), 64'(data_reg_o[i]), 64'(b.data[i]));
            end
        end
        if (flush_i) begin
            model_clear();
            sb_q.delete();
        end else if (acc) begin
            model_accept(rd_data_i, rd_last_i);
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic last);
        bit acc;
        int tries;
        rd_valid_i = 1'b1;
        rd_data_i  = d;
        rd_last_i  = last;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 50) begin
            step(acc);
            tries++;
        end
        if (!acc) check("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        bit acc;
        rd_valid_i = 1'b0;
        rd_last_i  = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        reset_n_i   = 1'b0;
        rd_data_i   = '0;
        rd_valid_i  = 1'b0;
        rd_last_i   = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        model_clear();

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_rd_ready", rd_ready_o, 1'b0);
        check("rst_out_valid", out_valid_o, 1'b0);
        check("rst_cnt", 64'(word_cnt_o), 64'd0);
        check("rst_data", 64'(|data_reg_o), 64'd0);
        reset_n_i = 1'b1;
        #1;
        check("rel_rd_ready_pre", rd_ready_o, 1'b0);
        @(posedge clk_i);
        #1;
        check("rel_rd_ready", rd_ready_o, 1'b1);

        // Test 1: full burst, latency one cycle
        for (int i = 1; i <= 8; i++) send(DATA_W'(i), i == 8);
        rd_valid_i = 1'b0;
        check("t1_latency", out_valid_o, 1'b1);
        idle(2);
        check("t1_drained", out_valid_o, 1'b0);

        // Test 2: short burst after all-ones burst
        for (int i = 0; i < 8; i++) send('1, 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) send(DATA_W'(32'hA0 + i), i == 2);
        idle(3);

        // Test 3: backpressure with both banks full
        out_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) send(DATA_W'(32'h300 + i), 1'b0);
        check("t3_ready_low", rd_ready_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(acc);
            check("t3_ready_hold", rd_ready_o, 1'b0);
        end
        rd_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step(acc);
        check("t3_ready_after_hs", rd_ready_o, 1'b1);
        idle(3);

        // Test 4: continuous throughput
        hs_cyc.delete();
        for (int i = 0; i < 24; i++) begin
            check("t4_ready", rd_ready_o, 1'b1);
            send(DATA_W'(32'h400 + i), (i % 8) == 7);
        end
        idle(3);
        check("t4_pulses", 64'(hs_cyc.size()), 64'd3);
        if (hs_cyc.size() == 3) begin
            check("t4_gap1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd8);
            check("t4_gap2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd8);
        end

        // Test 5: flush drops partial data and the concurrent word
        for (int i = 0; i < 5; i++) send(DATA_W'(32'h500 + i), 1'b0);
        rd_valid_i = 1'b1;
        rd_data_i  = 32'h505;
        rd_last_i  = 1'b1;
        flush_i    = 1'b1;
        step(acc);
        flush_i = 1'b0;
        rd_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5_no_valid", out_valid_o, 1'b0);
            step(acc);
        end
        for (int i = 0; i < 8; i++) send(DATA_W'(32'h510 + i), i == 7);
        idle(3);

        // Test 6: asynchronous reset mid-fill with a block pending
        out_ready_i = 1'b0;
        send(32'h600, 1'b0);
        send(32'h601, 1'b1);
        for (int i = 0; i < 4; i++) send(DATA_W'(32'h610 + i), 1'b0);
        rd_valid_i = 1'b0;
        check("t6_pending", out_valid_o, 1'b1);
        reset_n_i = 1'b0;
        #1;
        check("t6_rst_valid", out_valid_o, 1'b0);
        check("t6_rst_ready", rd_ready_o, 1'b0);
        check("t6_rst_cnt", 64'(word_cnt_o), 64'd0);
        check("t6_rst_data", 64'(|data_reg_o), 64'd0);
        model_clear();
        sb_q.delete();
        idle(2);
        reset_n_i = 1'b1;
        out_ready_i = 1'b1;
        idle(1);
        send(32'h620, 1'b0);
        send(32'h621, 1'b1);
        idle(3);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
